// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, multiplier op encoding and latency.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int MUL_LATENCY = XLEN + 2;

    typedef enum logic [1:0] {
        MUL_LO  = 2'd0,
        MUL_HSS = 2'd1,
        MUL_HSU = 2'd2,
        MUL_HUU = 2'd3
    } mul_op_e;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier for MUL/MULH/MULHSU/MULHU: sign-magnitude shift-add, then optional negate.
// Optional macro SEQ_MUL_ZERO_BYPASS_EN: a zero operand completes in one cycle without entering CALC.
module seq_multiplier
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  mul_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_NEG,
        S_DONE
    } state_e;

    localparam int CNT_W = $clog2(XLEN);

    state_e            state_q, state_d;
    mul_op_e           op_q, op_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              a_neg, b_neg;
    logic              accept;

    // Operands are reduced to unsigned magnitudes, so the most-negative value needs no special case.
    always_comb begin
        a_neg    = ((op == MUL_HSS) || (op == MUL_HSU)) && a[XLEN-1];
        b_neg    = (op == MUL_HSS) && b[XLEN-1];
        a_mag    = a_neg ? (~a + 1'b1) : a;
        b_mag    = b_neg ? (~b + 1'b1) : b;
        accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        prod_fin = neg_q ? (~prod_q + 1'b1) : prod_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= MUL_LO;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_d     = op;
                    neg_d    = a_neg ^ b_neg;
                    mcand_d  = {{XLEN{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    prod_d   = '0;
                    cnt_d    = CNT_W'(XLEN - 1);
                    state_d  = S_CALC;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
                    if ((a == '0) || (b == '0)) begin
                        neg_d    = 1'b0;
                        result_d = '0;
                        state_d  = S_DONE;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_NEG;
                end
            end
            S_NEG: begin
                prod_d   = prod_fin;
                result_d = (op_q == MUL_LO) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done   = (state_q == S_DONE);
        busy   = (state_q == S_CALC) || (state_q == S_NEG);
        result = result_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus random operands against an arithmetic model.
module tb_seq_multiplier;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    mul_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result = '0;

    seq_multiplier #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact 64-bit product of the sign/zero-extended operands, then pick the half.
    function automatic logic [31:0] ref_mul(input mul_op_e o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex;
        logic [63:0] ey;
        logic [63:0] p;
        ex = ((o == MUL_HSS) || (o == MUL_HSU)) ? {{32{x[31]}}, x} : {32'h0, x};
        ey = (o == MUL_HSS) ? {{32{y[31]}}, y} : {32'h0, y};
        p  = ex * ey;
        return (o == MUL_LO) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
        if ((x == 32'h0) || (y == 32'h0)) return 1;
`endif
        return MUL_LATENCY;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input mul_op_e o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
    endtask

    // Called right after issue(); returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input int lat, input int ign_k);
        int lat_seen;
        bit busy_ok;
        lat_seen = -1;
        busy_ok  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy !== (k < lat)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat_seen = k;
                start    = 1'b0;
                break;
            end
            if ((ign_k > 0) && (k == ign_k)) begin
                check({tag, " held"}, 64'(result), 64'(last_result));
            end
            start = ((ign_k > 0) && (k == ign_k)) ? 1'b1 : 1'b0;
            a     = $urandom;
            b     = $urandom;
            op    = mul_op_e'(2'($urandom_range(0, 3)));
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat_seen), 64'(lat));
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " busy"}, 64'(busy_ok), 64'(1));
        last_result = exp_res;
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        mul_op_e     o;

        reset = 1'b0;
        start = 1'b0;
        op    = MUL_LO;
        a     = '0;
        b     = '0;

        repeat (3) @(negedge clk);
        check("rst result", 64'(result), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        issue(MUL_LO, 32'd7, 32'd6);
        wait_done("lo 7x6", 32'h0000_002A, 34, 0);
        @(negedge clk);
        check("idle done", 64'(done), 64'(0));
        check("idle busy", 64'(busy), 64'(0));
        check("idle result", 64'(result), 64'(32'h0000_002A));

        issue(MUL_HSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("hss -1x-1", 32'h0000_0000, 34, 0);
        issue(MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("huu max", 32'hFFFF_FFFE, 34, 0);
        issue(MUL_LO, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("lo max", 32'h0000_0001, 34, 0);
        issue(MUL_HSU, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done("hsu -1x2", 32'hFFFF_FFFF, 34, 0);
        issue(MUL_HSS, 32'h8000_0000, 32'h8000_0000);
        wait_done("hss minneg", 32'h4000_0000, 34, 0);

        issue(MUL_HUU, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done("ignore start", ref_mul(MUL_HUU, 32'h1234_5678, 32'h9ABC_DEF0), 34, 5);
        issue(MUL_LO, 32'd2, 32'd2);
        wait_done("back2back", 32'd4, 34, 0);

        issue(MUL_LO, 32'd100, 32'd200);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort result", 64'(result), 64'(0));
        @(negedge clk);
        check("abort done2", 64'(done), 64'(0));
        reset = 1'b1;
        last_result = '0;
        issue(MUL_LO, 32'd3, 32'd5);
        wait_done("after reset", 32'd15, 34, 0);

        issue(MUL_LO, 32'h0, 32'h1234);
        wait_done("zero lo", 32'h0, exp_lat(32'h0, 32'h1234), 0);
        issue(MUL_HSS, 32'h8000_0000, 32'h0);
        wait_done("zero hss", 32'h0, exp_lat(32'h8000_0000, 32'h0), 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            x = pick_operand();
            y = pick_operand();
            o = mul_op_e'(2'($urandom_range(0, 3)));
            issue(o, x, y);
            wait_done($sformatf("rand%0d op%0d %h*%h", i, o, x, y), ref_mul(o, x, y), exp_lat(x, y), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have a parameter XLEN, default riscv_pkg::XLEN (32), which sets the operand and result width.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; every flop updates on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit: the reset is synchronous and active-low (0 = reset).
REQ-004 The block SHALL have input start, 1 bit: a request pulse from the ALU.
REQ-005 The block SHALL have input op, type mul_op_e: MUL_LO, MUL_HSS, MUL_HSU or MUL_HUU.
REQ-006 The block SHALL have input a, XLEN bits: the multiplicand (rs1).
REQ-007 The block SHALL have input b, XLEN bits: the multiplier (rs2).
REQ-008 The block SHALL have output result, XLEN bits: the selected product half.
REQ-009 The block SHALL have output done, 1 bit: a one-cycle pulse marking the cycle in which result first holds the new value.
REQ-010 The block SHALL have output busy, 1 bit: high while a multiply is in flight.

Function
REQ-011 States SHALL be IDLE, CALC, NEG and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; start in CALC or NEG SHALL be ignored, with no effect on state, result or outputs.
REQ-013 On acceptance in cycle T, op, a and b SHALL be captured, operand magnitudes and a negate flag SHALL be computed, and the next state SHALL be CALC.
- Signedness: a is signed for MUL_HSS and MUL_HSU; b is signed for MUL_HSS only; MUL_LO treats both as unsigned.
REQ-014 CALC SHALL perform radix-2 shift-add over a 2*XLEN product register, one multiplier bit per cycle, for exactly XLEN cycles (T+1..T+XLEN).
REQ-015 NEG (cycle T+XLEN+1) SHALL two's-complement negate the 2*XLEN product when the negate flag is set, otherwise hold it.
REQ-016 DONE SHALL be entered at T+XLEN+2; done SHALL be 1 in that cycle only; result SHALL be product[XLEN-1:0] for MUL_LO and product[2*XLEN-1:XLEN] otherwise.
REQ-017 The result register SHALL hold its value after DONE until the next accepted start.
REQ-018 busy SHALL be 1 in CALC and NEG and 0 in IDLE and DONE.
REQ-019 DONE SHALL go to IDLE unless start is asserted in that cycle, in which case it SHALL go to CALC (back-to-back issue).
REQ-020 The most-negative operand (0x80000000) SHALL be handled through unsigned magnitude arithmetic with no overflow special case.
REQ-021 Operand changes after the acceptance cycle SHALL not affect the result.

Reset
REQ-022 While reset == 0, state SHALL be IDLE, result 0, done 0, busy 0, and the product register and negate flag 0.
REQ-023 Reset asserted mid-operation SHALL abort the multiply with no done pulse, and a start in the first cycle after reset release SHALL be accepted.

Configuration
REQ-024 With macro SEQ_MUL_ZERO_BYPASS_EN defined, an accepted start with a == 0 or b == 0 SHALL go directly to DONE at T+1 with result 0 and busy never asserted.
REQ-025 Without SEQ_MUL_ZERO_BYPASS_EN, zero operands SHALL take the full XLEN+2-cycle latency of REQ-016.

Structure
REQ-026 mul_op_e (2-bit enum) and the constant MUL_LATENCY = XLEN+2 SHALL live in riscv_pkg; the state enum SHALL be local to the module.
REQ-027 The block SHALL be a single module with no sub-module; the adder and negator SHALL be inline.

Verification
REQ-028 MUL_LO, a=7, b=6, start at T -> done only at T+34, result 0x0000002A; busy high T+1..T+33.
REQ-029 a=b=0xFFFFFFFF -> MUL_HSS result 0x00000000; MUL_HUU result 0xFFFFFFFE; MUL_LO result 0x00000001.
REQ-030 MUL_HSU, a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF; MUL_HSS, a=b=0x80000000 -> 0x40000000.
REQ-031 Reset low at T+10 of a multiply -> busy 0 next cycle, no done pulse; a fresh MUL_LO 3*5 after release -> 15 at +34.
REQ-032 Handshake checks:
- start pulses at T+5 (in CALC) are ignored and the result is unchanged.
- start in the DONE cycle with 2*2 -> a second done 34 cycles later with result 4.
REQ-033 Zero operand: with SEQ_MUL_ZERO_BYPASS_EN, MUL_LO 0*0x1234 -> done at T+1, result 0; without the macro -> done at T+34, result 0.
